apb_acc_loader: RTL and testbench
=================================

// Module: apb_acc_loader
// PURPOSE
//   APB master (initiator) that moves 32-bit word bursts between a local stream interface and an APB
//   slave, primarily the accelerator's operand/result window (start/done at word 0, A/B/out buffers).
//   Accepts one command (address, length, direction), runs one APB transfer per word, handles PREADY
//   wait states and PSLVERR/timeout aborts, and reports completion. Sits between CPU-side control and APB.
// PARAMETERS
//   APB_ADDR_WIDTH  32    width of PADDR / cmd_addr
//   LEN_WIDTH       10    width of cmd_len (words per burst, 1..2**LEN_WIDTH-1)
//   TIMEOUT         255   max ACCESS cycles waiting for PREADY before abort (0 = no timeout)
// PORTS
//   HCLK         in   1               clock, all logic on rising edge
//   HRESETn      in   1               synchronous active-low reset
//   cmd_valid    in   1               command request
//   cmd_ready    out  1               high only in IDLE; cmd accepted when valid&ready
//   cmd_write    in   1               1 = stream->APB writes, 0 = APB reads->stream
//   cmd_addr     in   APB_ADDR_WIDTH  start byte address, word aligned (bits[1:0] ignored, forced 0)
//   cmd_len      in   LEN_WIDTH       number of words; 0 = accepted, completes with no APB traffic
//   wdata_valid  in   1               write word available
//   wdata_ready  out  1               write word consumed (valid&ready)
//   wdata        in   32              write word
//   rdata_valid  out  1               read word available
//   rdata_ready  in   1               read word consumed
//   rdata        out  32              read word (PRDATA captured at completion)
//   done         out  1               1-cycle pulse at end of command (normal or abort)
//   err          out  1               valid with done: 1 = PSLVERR or timeout; holds until next cmd accept
//   PADDR        out  APB_ADDR_WIDTH  APB address
//   PWDATA       out  32              APB write data
//   PWRITE       out  1               APB direction
//   PSEL         out  1               APB select
//   PENABLE      out  1               APB enable
//   PRDATA       in   32              APB read data
//   PREADY       in   1               APB ready
//   PSLVERR      in   1               APB slave error
// BEHAVIOUR
//   Reset: all outputs 0 except cmd_ready=1; FSM->IDLE; beat counter, timeout counter cleared.
//   Reset asserted mid-transfer drops PSEL/PENABLE at the next edge; no done pulse issued.
//   FSM: IDLE -> LOAD -> SETUP -> ACCESS -> (RHOLD) -> LOAD|FINISH -> IDLE.
//   IDLE: cmd_ready=1. On accept, latch addr (bits[1:0]=0), len, dir; clear err. len=0 -> FINISH.
//   LOAD: write: wdata_ready=1; on wdata_valid latch wdata into PWDATA -> SETUP. read: -> SETUP next cycle.
//   SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable; exactly one cycle -> ACCESS.
//   ACCESS: PSEL=1, PENABLE=1, signals held stable. Transfer completes on cycle with PREADY=1.
//     PREADY&PSLVERR -> err=1, abort -> FINISH (remaining beats dropped, no further APB traffic).
//     PREADY&~PSLVERR: write -> next beat; read -> capture PRDATA into rdata, rdata_valid=1 -> RHOLD.
//     PREADY=0 for TIMEOUT consecutive ACCESS cycles -> deassert PSEL/PENABLE, err=1 -> FINISH.
//   RHOLD: PSEL=0; hold rdata_valid until rdata_ready; then next beat. rdata_valid&rdata_ready in
//     the same cycle as capture is not possible (registered output; min 1 cycle in RHOLD).
//   Next beat: PADDR += 4 (wraps modulo 2**APB_ADDR_WIDTH), remaining -= 1; remaining=0 -> FINISH else LOAD.
//   FINISH: done=1 for one cycle, PSEL=PENABLE=0 -> IDLE.
//   PSEL/PENABLE low between beats (LOAD/RHOLD); min 3 cycles per write beat with no wait states.
//   PSLVERR ignored when PREADY=0. cmd_valid outside IDLE ignored (cmd_ready=0).
// TESTING
//   Write len=2 addr=0x004, wdata 0x11223344,0x55667788, PREADY=1 -> APB writes 0x004,0x008, done, err=0.
//   Read len=2 addr=0x804, PREADY delayed 3 cycles each -> rdata matches PRDATA, PENABLE held 4 cycles.
//   Read len=3, rdata_ready low 5 cycles on beat 1 -> PSEL=0 during hold, no lost/duplicated word.
//   Write len=4, PSLVERR on beat 2 -> 2 APB transfers only, done with err=1, next cmd clears err.
//   TIMEOUT=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, done with err=1; len=0 -> done, no PSEL.
//   HRESETn low during ACCESS -> next edge PSEL=PENABLE=0, cmd_ready=1, done stays 0.

Source files
------------

// File: rtl/apb_acc_loader.sv
// APB initiator that moves word bursts between a local stream port and an APB slave.
// One command runs one APB transfer per word, with wait-state, slave-error and timeout handling.
module apb_acc_loader #(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH      = 10,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]      cmd_len,
   input  logic                      wdata_valid,
   output logic                      wdata_ready,
   input  logic [31:0]               wdata,
   output logic                      rdata_valid,
   input  logic                      rdata_ready,
   output logic [31:0]               rdata,
   output logic                      done,
   output logic                      err,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      StIdle, StLoad, StSetup, StAccess, StRhold, StFinish
   } state_e;

   state_e               state;
   logic [LEN_WIDTH-1:0] remain;
   logic [TW-1:0]        tcnt;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state       <= StIdle;
         remain      <= '0;
         tcnt        <= '0;
         cmd_ready   <= 1'b1;
         wdata_ready <= 1'b0;
         rdata_valid <= 1'b0;
         rdata       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PWRITE      <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  PADDR     <= {cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                  PWRITE    <= cmd_write;
                  remain    <= cmd_len;
                  err       <= 1'b0;
                  if (cmd_len == '0) begin
                     done  <= 1'b1;
                     state <= StFinish;
                  end else begin
                     wdata_ready <= cmd_write;
                     state       <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (!PWRITE) begin
                  PSEL  <= 1'b1;
                  state <= StSetup;
               end else if (wdata_valid) begin
                  PWDATA      <= wdata;
                  wdata_ready <= 1'b0;
                  PSEL        <= 1'b1;
                  state       <= StSetup;
               end
            end
            StSetup: begin
               PENABLE <= 1'b1;
               tcnt    <= '0;
               state   <= StAccess;
            end
            StAccess: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= StFinish;
                  end else if (!PWRITE) begin
                     rdata       <= PRDATA;
                     rdata_valid <= 1'b1;
                     state       <= StRhold;
                  end else begin
                     PADDR  <= PADDR + APB_ADDR_WIDTH'(4);
                     remain <= remain - LEN_WIDTH'(1);
                     if (remain == LEN_WIDTH'(1)) begin
                        done  <= 1'b1;
                        state <= StFinish;
                     end else begin
                        wdata_ready <= 1'b1;
                        state       <= StLoad;
                     end
                  end
               end else if ((TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1))) begin
                  // Slave never answered: abandon the transfer and the rest of the burst.
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  err     <= 1'b1;
                  done    <= 1'b1;
                  state   <= StFinish;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            StRhold: begin
               if (rdata_ready) begin
                  rdata_valid <= 1'b0;
                  PADDR       <= PADDR + APB_ADDR_WIDTH'(4);
                  remain      <= remain - LEN_WIDTH'(1);
                  if (remain == LEN_WIDTH'(1)) begin
                     done  <= 1'b1;
                     state <= StFinish;
                  end else begin
                     state <= StLoad;
                  end
               end
            end
            StFinish: begin
               cmd_ready <= 1'b1;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_acc_loader.sv
// Randomized bench for apb_acc_loader: an APB slave model with random wait states and
// injected errors, random stream handshakes, and a burst-level model of the expected traffic.
module tb_apb_acc_loader;

   localparam int TO   = 8;
   localparam int NONE = 1000;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [9:0]  cmd_len;
   logic        wdata_valid, wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid, rdata_ready;
   logic [31:0] rdata;
   logic        done, err;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

   apb_acc_loader #(
      .APB_ADDR_WIDTH(32),
      .LEN_WIDTH     (10),
      .TIMEOUT       (TO)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .wdata      (wdata),
      .rdata_valid(rdata_valid),
      .rdata_ready(rdata_ready),
      .rdata      (rdata),
      .done       (done),
      .err        (err),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PWRITE     (PWRITE),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Scenario knobs and traffic logs shared by the driver processes.
   int err_beat = NONE, stuck_beat = NONE, wmin = 0, wmax = 0;
   int stall_beat = NONE, stall_left = 0;
   int beat = 0, setup_cnt = 0, acc_cyc = 0, cur_wait = 0;
   bit pending = 0, was_setup = 0, gap_chk = 0;
   logic [31:0] setup_addr;
   logic [31:0] words[$], wq[$], sent_q[$];
   logic [31:0] xfer_addr[$], xfer_wdata[$], slave_rd[$], got_rd[$];
   bit          xfer_wr[$];

   // APB slave model.
   always @(negedge HCLK) begin
      PREADY  = 1'b0;
      PSLVERR = 1'($urandom_range(1));
      PRDATA  = $urandom;
      if (!HRESETn) begin
         pending   = 0;
         acc_cyc   = 0;
         was_setup = 0;
         gap_chk   = 0;
      end else begin
         if (gap_chk) begin
            chk_eq("psel_gap", 32'(PSEL), 0);
            gap_chk = 0;
         end
         if (pending && !(PSEL && PENABLE)) begin
            chk_eq("abort_len", acc_cyc, (beat == stuck_beat) ? TO : 0);
            pending = 0;
            acc_cyc = 0;
         end
         if (PSEL && !PENABLE) begin
            setup_addr = PADDR;
            setup_cnt++;
            was_setup  = 1;
            cur_wait   = $urandom_range(wmax, wmin);
         end else if (PSEL && PENABLE) begin
            if (!pending) begin
               chk_eq("setup_first", 32'(was_setup), 1);
               pending = 1;
               acc_cyc = 0;
            end
            chk_eq("paddr_stable", PADDR, setup_addr);
            was_setup = 0;
            acc_cyc++;
            if (beat != stuck_beat && acc_cyc > cur_wait) begin
               PREADY  = 1'b1;
               PSLVERR = (beat == err_beat);
               xfer_addr.push_back(PADDR);
               xfer_wr.push_back(PWRITE);
               xfer_wdata.push_back(PWDATA);
               if (!PWRITE && !PSLVERR) slave_rd.push_back(PRDATA);
               beat++;
               pending = 0;
               acc_cyc = 0;
               gap_chk = 1;
            end
         end
      end
   end

   // Stream side: offer queued write words, accept read words with random back-pressure.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         wdata_valid = 1'b0;
         rdata_ready = 1'b0;
      end else begin
         wdata_valid = (wq.size() > 0) && ($urandom_range(3) != 0);
         if (wdata_valid) wdata = wq[0];
         else             wdata = $urandom;
         if (wdata_valid && wdata_ready) sent_q.push_back(wq.pop_front());
         rdata_ready = 1'($urandom_range(1));
         if (rdata_valid) begin
            chk_eq("psel_rhold", 32'(PSEL), 0);
            if (got_rd.size() == stall_beat && stall_left > 0) begin
               rdata_ready = 1'b0;
               stall_left--;
            end
         end
         if (rdata_valid && rdata_ready) got_rd.push_back(rdata);
      end
   end

   task automatic clear_logs();
      wq.delete(); sent_q.delete(); words.delete();
      xfer_addr.delete(); xfer_wdata.delete(); xfer_wr.delete();
      slave_rd.delete(); got_rd.delete();
      beat = 0;
      setup_cnt = 0;
   endtask

   task automatic run_cmd(input bit w, input logic [31:0] addr, input int len, input int eb,
                          input int sb, input int wlo, input int whi, input int sbeat,
                          input int sleft);
      int nxf, nok, ncons, nsetup;
      bit experr, seen;
      logic [31:0] exp_a;
      clear_logs();
      err_beat = eb; stuck_beat = sb; wmin = wlo; wmax = whi;
      stall_beat = sbeat; stall_left = sleft;
      for (int i = 0; i < len; i++) words.push_back($urandom);
      if (eb < len) begin
         nxf = eb + 1; nok = eb; ncons = eb + 1; nsetup = eb + 1; experr = 1;
      end else if (sb < len) begin
         nxf = sb; nok = sb; ncons = sb + 1; nsetup = sb + 1; experr = 1;
      end else begin
         nxf = len; nok = len; ncons = len; nsetup = len; experr = 0;
      end
      @(negedge HCLK);
      if (w) wq = words;
      chk_eq("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_len = 10'(len);
      seen = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge HCLK);
         if (c == 0) begin
            chk_eq("err_cleared", 32'(err), 0);
            chk_eq("cmd_ready_busy", 32'(cmd_ready), 0);
         end
         if (done) begin
            seen = 1;
            break;
         end
         // Commands offered while busy must be ignored.
         cmd_valid = !cmd_ready && ($urandom_range(1) != 0);
         cmd_write = 1'($urandom_range(1));
         cmd_addr  = $urandom;
         cmd_len   = 10'($urandom);
      end
      chk_eq("done_seen", 32'(seen), 1);
      chk_eq("err_at_done", 32'(err), 32'(experr));
      @(negedge HCLK);
      cmd_valid = 1'b0;
      wq.delete();
      chk_eq("done_pulse", 32'(done), 0);
      chk_eq("cmd_ready_back", 32'(cmd_ready), 1);
      chk_eq("err_hold", 32'(err), 32'(experr));
      chk_eq("xfer_count", xfer_addr.size(), nxf);
      chk_eq("setup_count", setup_cnt, nsetup);
      for (int i = 0; i < nxf && i < xfer_addr.size(); i++) begin
         exp_a = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
         chk_eq("paddr", xfer_addr[i], exp_a);
         chk_eq("pwrite", 32'(xfer_wr[i]), 32'(w));
         if (w) chk_eq("pwdata", xfer_wdata[i], words[i]);
      end
      chk_eq("wdata_taken", sent_q.size(), w ? ncons : 0);
      if (!w) begin
         chk_eq("rd_count", got_rd.size(), nok);
         for (int i = 0; i < got_rd.size() && i < slave_rd.size(); i++)
            chk_eq("rdata", got_rd[i], slave_rd[i]);
      end
   endtask

   task automatic reset_mid();
      bit found;
      clear_logs();
      err_beat = NONE; stuck_beat = 0; wmin = 0; wmax = 0;
      @(negedge HCLK);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_len = 10'd2;
      @(negedge HCLK);
      cmd_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         if (PENABLE) begin
            found = 1;
            break;
         end
         @(negedge HCLK);
      end
      chk_eq("reach_access", 32'(found), 1);
      HRESETn = 1'b0;
      @(negedge HCLK);
      chk_eq("rst_psel", 32'(PSEL), 0);
      chk_eq("rst_penable", 32'(PENABLE), 0);
      chk_eq("rst_cmd_ready", 32'(cmd_ready), 1);
      chk_eq("rst_done", 32'(done), 0);
      @(negedge HCLK);
      chk_eq("rst_done2", 32'(done), 0);
      HRESETn = 1'b1;
   endtask

   initial begin
      int w, len, eb, sb;
      HRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      repeat (3) @(negedge HCLK);
      chk_eq("reset_cmd_ready", 32'(cmd_ready), 1);
      chk_eq("reset_psel", 32'(PSEL), 0);
      chk_eq("reset_penable", 32'(PENABLE), 0);
      chk_eq("reset_done", 32'(done), 0);
      chk_eq("reset_err", 32'(err), 0);
      chk_eq("reset_wready", 32'(wdata_ready), 0);
      chk_eq("reset_rvalid", 32'(rdata_valid), 0);
      chk_eq("reset_paddr", PADDR, 0);
      HRESETn = 1'b1;

      run_cmd(1, 32'h004, 2, NONE, NONE, 0, 0, NONE, 0);
      run_cmd(0, 32'h804, 2, NONE, NONE, 3, 3, NONE, 0);
      run_cmd(0, 32'h100, 3, NONE, NONE, 0, 2, 1, 5);
      run_cmd(1, 32'h200, 4, 1, NONE, 0, 1, NONE, 0);
      run_cmd(1, 32'h300, 1, NONE, NONE, 0, 0, NONE, 0);
      run_cmd(1, 32'h040, 2, NONE, 0, 0, 0, NONE, 0);
      run_cmd(0, 32'h043, 0, NONE, NONE, 0, 0, NONE, 0);
      run_cmd(0, 32'hFFFF_FFF9, 3, NONE, NONE, 0, 1, NONE, 0);
      run_cmd(0, 32'h500, 3, NONE, 2, 0, 1, NONE, 0);
      reset_mid();
      run_cmd(1, 32'h600, 2, NONE, NONE, 0, 2, NONE, 0);

      for (int k = 0; k < 40; k++) begin
         w   = $urandom_range(1);
         len = $urandom_range(6, 0);
         eb  = ($urandom_range(4) == 0) ? $urandom_range(len) : NONE;
         sb  = (eb == NONE && $urandom_range(5) == 0) ? $urandom_range(len) : NONE;
         run_cmd(w[0], $urandom, len, eb, sb, 0, $urandom_range(4), $urandom_range(3),
                 $urandom_range(6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
